uart_rx: RTL and testbench

Receive half of the UART link. Deserialises the asynchronous `RX_IN` line into 8-bit bytes at `OVERSAMPLE` clocks per bit, with a 3-sample majority vote at mid-bit, optional parity check and stop-bit check. It sits behind the pad or loopback from the UART transmitter and hands each good byte to the consumer as a one-cycle `DATA_valid` strobe. Its frame format matches the transmitter's: start 0, 8 data bits LSB first, optional parity, stop 1.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_if.sv | 35 +++
 rtl/uart_rx_sampler.sv | 83 ++++++++
 rtl/uart_rx.sv | 162 ++++++++++++++++
 tb/tb_uart_rx.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions: receiver/transmitter state encoding
//               and the data word width.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int DATA_W = 8;

    // Encoding is shared with the transmitter and its assertions; keep values.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_if
// Description : Consumer-side bundle of the UART receiver.
//               PAR_EN/PAR_TYP  : frame format (sampled at frame start)
//               P_DATA          : last good byte
//               DATA_valid      : one-cycle strobe, P_DATA is new
//               PAR_ERR/STP_ERR : one-cycle error strobes, frame dropped
//               busy            : receiver is inside a frame
//               master = receiver side, slave = consumer side.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_if;
    import uart_pkg::*;

    logic              PAR_EN;
    logic              PAR_TYP;
    logic [DATA_W-1:0] P_DATA;
    logic              DATA_valid;
    logic              PAR_ERR;
    logic              STP_ERR;
    logic              busy;

    modport master (
        input  PAR_EN, PAR_TYP,
        output P_DATA, DATA_valid, PAR_ERR, STP_ERR, busy
    );

    modport slave (
        output PAR_EN, PAR_TYP,
        input  P_DATA, DATA_valid, PAR_ERR, STP_ERR, busy
    );

endinterface : uart_rx_if
`default_nettype wire

// File: rtl/uart_rx_sampler.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_sampler
// Description : Bit-timing front end of the UART receiver: 2-flop input
//               synchroniser, prescale counter and 3-sample majority vote.
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_rx        : raw serial line (asynchronous)
//   i_clear     : hold the prescale counter at 0 (receiver idle)
//   o_rx_sync   : synchronised line
//   bit_val     : majority-voted bit value, valid with bit_tick
//   bit_tick    : one-cycle decision strobe (mid-bit)
//   bit_end     : one-cycle strobe on the counter wrap (end of bit period)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_sampler #(
    parameter int OVERSAMPLE = 8
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_rx,
    input  wire logic i_clear,
    output logic      o_rx_sync,
    output logic      bit_val,
    output logic      bit_tick,
    output logic      bit_end
);

    localparam int CW = $clog2(OVERSAMPLE);

    // The counter value in a cycle is the value it takes one edge later minus
    // one, so comparing against (target - 1) makes the sample/decision happen
    // on the edge at which the counter reaches the target value.
    localparam logic [CW-1:0] c_samp0 = CW'(OVERSAMPLE/2 - 2);
    localparam logic [CW-1:0] c_samp1 = CW'(OVERSAMPLE/2 - 1);
    localparam logic [CW-1:0] c_dec   = CW'(OVERSAMPLE/2);
    localparam logic [CW-1:0] c_last  = CW'(OVERSAMPLE - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic [CW-1:0] r_cnt;
    logic          r_samp0;
    logic          r_samp1;

    // Both flops reset to the idle (high) level so reset never looks like a
    // start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_rx;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear || (r_cnt == c_last)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_samp0 <= 1'b1;
            r_samp1 <= 1'b1;
        end else if (!i_clear) begin
            if (r_cnt == c_samp0) r_samp0 <= r_sync2;
            if (r_cnt == c_samp1) r_samp1 <= r_sync2;
        end
    end

    // Third sample is the live synchronised line at the decision edge.
    assign bit_val   = (r_samp0 & r_samp1) | (r_samp0 & r_sync2) | (r_samp1 & r_sync2);
    assign bit_tick  = !i_clear && (r_cnt == c_dec);
    assign bit_end   = !i_clear && (r_cnt == c_last);
    assign o_rx_sync = r_sync2;

endmodule : uart_rx_sampler
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : UART receiver. Frames are start(0), 8 data bits LSB first,
//               optional parity, stop(1). Good bytes are presented on P_DATA
//               with a one-cycle DATA_valid; bad frames raise exactly one of
//               PAR_ERR / STP_ERR for one cycle and are dropped.
//   clk, rst_n : clock, asynchronous active-low reset
//   RX_IN      : serial line, idle high, asynchronous
//   bus        : uart_rx_if.master (format inputs, data and status outputs)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 8
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic RX_IN,
    uart_rx_if.master bus
);

    localparam int IW = $clog2(DATA_W);
    localparam logic [IW-1:0] c_last_idx = IW'(DATA_W - 1);

    uart_state_t       r_state;
    uart_state_t       w_next;
    logic              r_par_en;
    logic              r_par_typ;
    logic              r_par_bad;
    logic [IW-1:0]     r_idx;
    logic [DATA_W-1:0] r_byte;
    logic [DATA_W-1:0] r_p_data;
    logic              r_valid;
    logic              r_par_err;
    logic              r_stp_err;

    logic w_clear;
    logic w_rx_sync;
    logic w_bit_val;
    logic w_bit_tick;
    logic w_bit_end;
    logic w_frame_start;
    logic w_shift_en;
    logic w_idx_inc;
    logic w_par_chk;
    logic w_good;
    logic w_par_fail;
    logic w_stp_fail;
    logic w_par_exp;

    assign w_clear = (r_state == IDLE);

    uart_rx_sampler #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_sampler (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_rx      (RX_IN),
        .i_clear   (w_clear),
        .o_rx_sync (w_rx_sync),
        .bit_val   (w_bit_val),
        .bit_tick  (w_bit_tick),
        .bit_end   (w_bit_end)
    );

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:   if (!w_rx_sync) w_next = START;
            START: begin
                if (w_bit_tick && w_bit_val) w_next = IDLE;   // glitch, not a start bit
                else if (w_bit_end)          w_next = DATA;
            end
            DATA:   if (w_bit_end && (r_idx == c_last_idx)) w_next = r_par_en ? PARITY : STOP;
            PARITY: if (w_bit_end) w_next = STOP;
            STOP:   if (w_bit_tick) w_next = IDLE;            // no wait for the wrap
            default: w_next = IDLE;
        endcase
    end

    // ---------------- output / control decode ----------------
    always_comb begin
        w_frame_start = 1'b0;
        w_shift_en    = 1'b0;
        w_idx_inc     = 1'b0;
        w_par_chk     = 1'b0;
        w_good        = 1'b0;
        w_par_fail    = 1'b0;
        w_stp_fail    = 1'b0;
        case (r_state)
            IDLE:   w_frame_start = !w_rx_sync;
            DATA: begin
                w_shift_en = w_bit_tick;
                w_idx_inc  = w_bit_end;
            end
            PARITY: w_par_chk = w_bit_tick;
            STOP: begin
                // Stop-bit error outranks a parity error.
                w_stp_fail = w_bit_tick && !w_bit_val;
                w_par_fail = w_bit_tick &&  w_bit_val &&  r_par_bad;
                w_good     = w_bit_tick &&  w_bit_val && !r_par_bad;
            end
            default: ;
        endcase
    end

    assign w_par_exp = r_par_typ ? (^r_byte) : (~^r_byte);

    // ---------------- frame datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par_en  <= 1'b0;
            r_par_typ <= 1'b0;
            r_par_bad <= 1'b0;
            r_idx     <= '0;
            r_byte    <= '0;
        end else begin
            if (w_frame_start) begin
                // Format is frozen for the whole frame.
                r_par_en  <= bus.PAR_EN;
                r_par_typ <= bus.PAR_TYP;
                r_par_bad <= 1'b0;
                r_idx     <= '0;
            end
            if (w_shift_en) r_byte[r_idx] <= w_bit_val;
            if (w_idx_inc)  r_idx <= r_idx + IW'(1);
            if (w_par_chk)  r_par_bad <= (w_bit_val != w_par_exp);
        end
    end

    // ---------------- output registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p_data  <= '0;
            r_valid   <= 1'b0;
            r_par_err <= 1'b0;
            r_stp_err <= 1'b0;
        end else begin
            r_valid   <= w_good;
            r_par_err <= w_par_fail;
            r_stp_err <= w_stp_fail;
            if (w_good) r_p_data <= r_byte;
        end
    end

    assign bus.P_DATA     = r_p_data;
    assign bus.DATA_valid = r_valid;
    assign bus.PAR_ERR    = r_par_err;
    assign bus.STP_ERR    = r_stp_err;
    assign bus.busy       = (r_state != IDLE);

endmodule : uart_rx
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx
// Description : Directed self-checking bench for uart_rx (OVERSAMPLE = 8).
//               Frame timing reference: E is the clock edge after which the
//               start bit is driven; the synchronised low is registered at
//               E+3 (t0) and the outcome strobe is visible after edge E+8*N.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int OS = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic rx;
    int   cyc = 0;

    int n_checks = 0;
    int n_fail   = 0;

    // strobe / busy monitor state
    int          n_valid = 0, n_par = 0, n_stp = 0;
    int          last_valid_cyc = -1, prev_valid_cyc = -1;
    int          last_par_cyc = -1, last_stp_cyc = -1;
    int          busy_rise = -1, busy_fall = -1;
    logic        busy_q = 1'b0;
    logic [7:0]  last_data = 8'h00, prev_data = 8'h00;

    int e, e2, nv, np, ns;

    uart_rx_if bus ();

    uart_rx #(
        .OVERSAMPLE (OS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .RX_IN (rx),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.DATA_valid === 1'b1) begin
            n_valid++;
            prev_valid_cyc = last_valid_cyc;
            last_valid_cyc = cyc;
            prev_data      = last_data;
            last_data      = bus.P_DATA;
        end
        if (bus.PAR_ERR === 1'b1) begin n_par++; last_par_cyc = cyc; end
        if (bus.STP_ERR === 1'b1) begin n_stp++; last_stp_cyc = cyc; end
        if (bus.busy === 1'b1 && !busy_q) busy_rise = cyc;
        if (bus.busy === 1'b0 &&  busy_q) busy_fall = cyc;
        busy_q = (bus.busy === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Must be entered at a falling edge; returns the edge index E.
    task automatic send_frame(input logic [7:0] d, input bit par_on, input bit par_bit,
                              input bit stop_bit, input int spike_bit, output int e_out);
        logic [10:0] bits;
        int nb;
        e_out = cyc;
        if (par_on) begin bits = {stop_bit, par_bit, d, 1'b0}; nb = 11; end
        else        begin bits = {1'b0, stop_bit, d, 1'b0};    nb = 10; end
        for (int i = 0; i < nb; i++) begin
            rx = bits[i];
            if (i == spike_bit) begin
                // invert only the middle of the three vote samples
                repeat (OS/2) @(negedge clk);
                rx = ~bits[i];
                @(negedge clk);
                rx = bits[i];
                repeat (OS/2 - 1) @(negedge clk);
            end else begin
                repeat (OS) @(negedge clk);
            end
        end
        rx = 1'b1;
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        rx = 1'b1;
        bus.PAR_EN  = 1'b0;
        bus.PAR_TYP = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_p_data", bus.P_DATA, 8'h00);
        check("rst_valid",  bus.DATA_valid, 1'b0);
        check("rst_par",    bus.PAR_ERR, 1'b0);
        check("rst_stp",    bus.STP_ERR, 1'b0);
        check("rst_busy",   bus.busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // ---- good frame, no parity ----
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, -1, e);
        settle();
        check("a5_data",       bus.P_DATA, 8'hA5);
        check("a5_nvalid",     n_valid, 1);
        check("a5_strobe_cyc", last_valid_cyc, e + 80);
        check("a5_nerr",       n_par + n_stp, 0);
        check("a5_busy_rise",  busy_rise, e + 3);
        check("a5_busy_fall",  busy_fall, e + 80);
        check("a5_busy_after", bus.busy, 1'b0);

        // ---- parity good (0x3C, even number of ones, PAR_TYP=1 -> bit 0) ----
        bus.PAR_EN  = 1'b1;
        bus.PAR_TYP = 1'b1;
        @(negedge clk);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, -1, e);
        settle();
        check("parok_data",   bus.P_DATA, 8'h3C);
        check("parok_nvalid", n_valid, 2);
        check("parok_cyc",    last_valid_cyc, e + 88);
        check("parok_npar",   n_par, 0);

        // ---- parity bad ----
        @(negedge clk);
        send_frame(8'h3C, 1'b1, 1'b1, 1'b1, -1, e);
        settle();
        check("parbad_npar",   n_par, 1);
        check("parbad_cyc",    last_par_cyc, e + 88);
        check("parbad_nvalid", n_valid, 2);
        check("parbad_data",   bus.P_DATA, 8'h3C);

        // ---- stop error, no parity ----
        bus.PAR_EN = 1'b0;
        @(negedge clk);
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, -1, e);
        settle();
        check("stp_nstp",   n_stp, 1);
        check("stp_cyc",    last_stp_cyc, e + 80);
        check("stp_nvalid", n_valid, 2);
        check("stp_npar",   n_par, 1);
        check("stp_data",   bus.P_DATA, 8'h3C);
        repeat (30) @(posedge clk);
        #1;
        check("stp_idle", bus.busy, 1'b0);

        // ---- stop error outranks bad parity ----
        bus.PAR_EN = 1'b1;
        @(negedge clk);
        send_frame(8'h3C, 1'b1, 1'b1, 1'b0, -1, e);
        settle();
        check("prio_nstp", n_stp, 2);
        check("prio_npar", n_par, 1);
        repeat (30) @(posedge clk);

        // ---- start glitch: 2 clocks low ----
        bus.PAR_EN = 1'b0;
        @(negedge clk);
        e = cyc;
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        check("glitch_busy_hi", bus.busy, 1'b1);
        @(negedge clk);
        check("glitch_busy_lo", bus.busy, 1'b0);
        repeat (10) @(negedge clk);
        check("glitch_nostrobe", n_valid + n_par + n_stp, 5);
        send_frame(8'h55, 1'b0, 1'b0, 1'b1, -1, e);
        settle();
        check("g55_data",   bus.P_DATA, 8'h55);
        check("g55_nvalid", n_valid, 3);

        // ---- noise spikes + back-to-back frames ----
        @(negedge clk);
        send_frame(8'h12, 1'b0, 1'b0, 1'b1, 3, e);   // spike on data bit 2 (0)
        send_frame(8'h34, 1'b0, 1'b0, 1'b1, 6, e2);  // spike on data bit 5 (1)
        settle();
        check("b2b_nvalid", n_valid, 5);
        check("b2b_first",  prev_data, 8'h12);
        check("b2b_second", bus.P_DATA, 8'h34);
        check("b2b_gap",    last_valid_cyc - prev_valid_cyc, 80);
        check("b2b_cyc",    last_valid_cyc, e2 + 80);
        check("b2b_nerr",   n_par + n_stp, 3);

        // ---- reset during data bit 4 ----
        @(negedge clk);
        rx = 1'b0;
        repeat (OS) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = 1'b1;
            repeat (OS) @(negedge clk);
        end
        rx = 1'b1;
        repeat (3) @(negedge clk);
        nv = n_valid; np = n_par; ns = n_stp;
        check("mid_busy_before", bus.busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_data",  bus.P_DATA, 8'h00);
        check("mid_rst_busy",  bus.busy, 1'b0);
        check("mid_rst_valid", bus.DATA_valid, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (120) @(negedge clk);
        check("mid_no_strobe", (n_valid - nv) + (n_par - np) + (n_stp - ns), 0);
        check("mid_idle",      bus.busy, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0, 1'b1, -1, e);
        settle();
        check("f0_data",   bus.P_DATA, 8'hF0);
        check("f0_nvalid", n_valid, nv + 1);
        check("f0_cyc",    last_valid_cyc, e + 80);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_uart_rx
`default_nettype wire
